// File: rtl/modu_ampl_ramp_ctrl_pkg.sv
// Shared encodings and constants for the modulation amplitude ramp controller.
// The ramp FSM and the scale/saturate datapath both import this package.
package modu_ampl_ramp_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_DONE = 2'd2
    } ramp_state_e;

    localparam int UNITY_GAIN = 128;
    localparam int GAIN_SHIFT = 7;
    localparam int MIDSCALE   = 2048;

    // Midscale code of an offset-binary sample of the given width.
    function automatic int midscale(input int dw);
        return 1 << (dw - 1);
    endfunction

endpackage

// File: rtl/modu_ampl_scale_sat.sv
// Two-stage modulation datapath: recentre, multiply by gain, rescale, add offset,
// then saturate back into the unsigned offset-binary DAC range.
module modu_ampl_scale_sat
    import modu_ampl_ramp_ctrl_pkg::*;
#(
    parameter int DW = 12,
    parameter int GW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DW-1:0]        sample,
    input  logic [GW-1:0]        gain,
    input  logic signed [DW-1:0] offset,
    output logic [DW-1:0]        ampl
);

    localparam int PW = DW + GW + 1;
    localparam logic [DW:0]          MID_C   = (DW+1)'(midscale(DW));
    localparam logic [DW-1:0]        MID_OUT = DW'(midscale(DW));
    localparam logic signed [PW-1:0] MAX_C   = PW'((1 << DW) - 1);

    logic signed [DW:0]    centred_s;
    logic signed [PW-1:0]  prod_s;
    logic signed [PW-1:0]  prod_r;
    logic signed [DW-1:0]  ofs_r;
    logic signed [PW-1:0]  sum_s;
    logic [DW-1:0]         clamp_s;
    logic [DW-1:0]         ampl_r;

    // Stage-1 operands: signed sample around midscale times the unsigned gain.
    always_comb begin
        centred_s = $signed({1'b0, sample}) - $signed(MID_C);
        prod_s    = $signed({{GW{centred_s[DW]}}, centred_s})
                  * $signed({{(DW+1){1'b0}}, gain});
    end

    // Stage-2: floor-rescale, add offset and midscale, clamp to the DAC code range.
    always_comb begin
        sum_s = (prod_r >>> GAIN_SHIFT)
              + $signed({{(GW+1){ofs_r[DW-1]}}, ofs_r})
              + $signed({{GW{1'b0}}, MID_C});
        if (sum_s[PW-1]) begin
            clamp_s = {DW{1'b0}};
        end else if (sum_s > MAX_C) begin
            clamp_s = {DW{1'b1}};
        end else begin
            clamp_s = sum_s[DW-1:0];
        end
    end

    // Pipeline registers; the offset travels alongside the product it belongs to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_r <= {PW{1'b0}};
            ofs_r  <= {DW{1'b0}};
            ampl_r <= MID_OUT;
        end else begin
            prod_r <= prod_s;
            ofs_r  <= offset;
            ampl_r <= clamp_s;
        end
    end

    assign ampl = ampl_r;

endmodule

// File: rtl/modu_ampl_ramp_ctrl.sv
// Gain/offset scheduler for the modulation DAC path: accepts new targets over
// valid/ready and slews the live gain and offset toward them one tick at a time.
module modu_ampl_ramp_ctrl
    import modu_ampl_ramp_ctrl_pkg::*;
#(
    parameter int            DW        = 12,
    parameter int            GW        = 8,
    parameter logic [GW-1:0] INIT_GAIN = GW'(UNITY_GAIN),
    parameter int            OFS_STEP  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] dac_modu,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [GW-1:0] cfg_gain,
    input  logic [DW-1:0] cfg_offset,
    input  logic [15:0]   cfg_ramp_div,
    output logic [DW-1:0] dac_modu_ampl,
    output logic          busy,
    output logic          ramp_done,
    output logic [GW-1:0] gain_cur
);

    localparam logic [GW-1:0]        GAIN_ONE = GW'(1);
    localparam logic [DW-1:0]        STEP_N   = DW'(OFS_STEP);
    localparam logic signed [DW:0]   STEP_C   = (DW+1)'(OFS_STEP);
    localparam logic signed [DW:0]   NSTEP_C  = -STEP_C;

    ramp_state_e           state_r;
    ramp_state_e           state_nx_s;
    logic [15:0]           cnt_r;
    logic [15:0]           cnt_nx_s;
    logic [15:0]           div_r;
    logic [GW-1:0]         gain_tgt_r;
    logic [GW-1:0]         gain_cur_r;
    logic [GW-1:0]         gain_step_s;
    logic signed [DW-1:0]  ofs_tgt_r;
    logic signed [DW-1:0]  ofs_cur_r;
    logic signed [DW-1:0]  ofs_step_s;
    logic signed [DW:0]    ofs_diff_s;
    logic                  accept_s;
    logic                  tick_s;
    logic                  cfg_ready_r;
    logic                  busy_r;
    logic                  ramp_done_r;

    // One tick's worth of movement; the offset step shrinks near the target so it never overshoots.
    always_comb begin
        ofs_diff_s = {ofs_tgt_r[DW-1], ofs_tgt_r} - {ofs_cur_r[DW-1], ofs_cur_r};
        if (gain_cur_r < gain_tgt_r) begin
            gain_step_s = gain_cur_r + GAIN_ONE;
        end else if (gain_cur_r > gain_tgt_r) begin
            gain_step_s = gain_cur_r - GAIN_ONE;
        end else begin
            gain_step_s = gain_cur_r;
        end
        if (ofs_diff_s > STEP_C) begin
            ofs_step_s = ofs_cur_r + STEP_N;
        end else if (ofs_diff_s < NSTEP_C) begin
            ofs_step_s = ofs_cur_r - STEP_N;
        end else begin
            ofs_step_s = ofs_tgt_r;
        end
    end

    // Next-state logic: handshake in IDLE, tick divider in RAMP, single-cycle DONE.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        accept_s   = 1'b0;
        tick_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cfg_valid && cfg_ready_r) begin
                    accept_s = 1'b1;
                    cnt_nx_s = 16'd0;
                    if ((cfg_gain == gain_cur_r) && (cfg_offset == ofs_cur_r)) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        state_nx_s = ST_RAMP;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RAMP: begin
                if (cnt_r == div_r) begin
                    tick_s   = 1'b1;
                    cnt_nx_s = 16'd0;
                    if ((gain_step_s == gain_tgt_r) && (ofs_step_s == ofs_tgt_r)) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        state_nx_s = ST_RAMP;
                    end
                end else begin
                    cnt_nx_s   = cnt_r + 16'd1;
                    state_nx_s = ST_RAMP;
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
                cnt_nx_s   = 16'd0;
            end
        endcase
    end

    // Control state, latched targets, live values and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 16'd0;
            div_r       <= 16'd0;
            gain_tgt_r  <= INIT_GAIN;
            ofs_tgt_r   <= {DW{1'b0}};
            gain_cur_r  <= INIT_GAIN;
            ofs_cur_r   <= {DW{1'b0}};
            cfg_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            ramp_done_r <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            if (accept_s) begin
                div_r      <= cfg_ramp_div;
                gain_tgt_r <= cfg_gain;
                ofs_tgt_r  <= $signed(cfg_offset);
            end
            if (tick_s) begin
                gain_cur_r <= gain_step_s;
                ofs_cur_r  <= ofs_step_s;
            end
            cfg_ready_r <= (state_nx_s == ST_IDLE);
            busy_r      <= (state_nx_s == ST_RAMP);
            ramp_done_r <= (state_nx_s == ST_DONE);
        end
    end

    modu_ampl_scale_sat #(
        .DW (DW),
        .GW (GW)
    ) u_scale_sat (
        .clk    (clk),
        .rst    (rst),
        .sample (dac_modu),
        .gain   (gain_cur_r),
        .offset (ofs_cur_r),
        .ampl   (dac_modu_ampl)
    );

    assign cfg_ready = cfg_ready_r;
    assign busy      = busy_r;
    assign ramp_done = ramp_done_r;
    assign gain_cur  = gain_cur_r;

endmodule

// File: tb/tb_modu_ampl_ramp_ctrl.sv
// Self-checking bench for modu_ampl_ramp_ctrl: directed scenarios plus randomized
// ramps and sample streams, all checked against a closed-form reference model.
module tb_modu_ampl_ramp_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] dac_modu = 12'h800;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [7:0]  cfg_gain = 8'd0;
    logic [11:0] cfg_offset = 12'd0;
    logic [15:0] cfg_ramp_div = 16'd0;
    logic [11:0] dac_modu_ampl;
    logic        busy;
    logic        ramp_done;
    logic [7:0]  gain_cur;

    int n_vec = 0;
    int n_err = 0;
    int m_gain = 128;
    int m_ofs  = 0;

    modu_ampl_ramp_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .dac_modu      (dac_modu),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_gain      (cfg_gain),
        .cfg_offset    (cfg_offset),
        .cfg_ramp_div  (cfg_ramp_div),
        .dac_modu_ampl (dac_modu_ampl),
        .busy          (busy),
        .ramp_done     (ramp_done),
        .gain_cur      (gain_cur)
    );

    always #5 clk = ~clk;

    // Reference: output code for a sample under a given gain and offset.
    function automatic int exp_out(input int s, input int g, input int o);
        int v;
        v = (((s - 2048) * g) >>> 7) + o + 2048;
        if (v < 0) return 0;
        if (v > 4095) return 4095;
        return v;
    endfunction

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    // Ticks needed: gain moves 1 per tick, offset up to 4 per tick.
    function automatic int n_ticks(input int g0, input int gt, input int o0, input int ot);
        int a;
        int b;
        a = iabs(gt - g0);
        b = (iabs(ot - o0) + 3) / 4;
        return (a > b) ? a : b;
    endfunction

    // Value after k ticks of at most 'step' toward vt.
    function automatic int toward(input int v0, input int vt, input int step, input int k);
        int d;
        d = vt - v0;
        if (iabs(d) <= k * step) return vt;
        return (d > 0) ? v0 + k * step : v0 - k * step;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cfg_valid = 1'b0;
        dac_modu = 12'h800;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        step();
        m_gain = 128;
        m_ofs  = 0;
    endtask

    // Present a target for exactly one accepting edge; returns just after that edge.
    task automatic apply_cfg(input int g, input int o, input int d);
        cfg_gain     = 8'(g);
        cfg_offset   = 12'(o);
        cfg_ramp_div = 16'(d);
        cfg_valid    = 1'b1;
        step();
        cfg_valid    = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (dac_modu_ampl !== 12'h800) begin n_err++; $display("FAIL reset_out got %h exp 800", dac_modu_ampl); end
        n_vec++; if (gain_cur !== 8'd128) begin n_err++; $display("FAIL reset_gain got %0d exp 128", gain_cur); end
        n_vec++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b exp 1", cfg_ready); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_vec++; if (ramp_done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", ramp_done); end
    endtask

    task automatic test_passthrough();
        int xs[3] = '{'h123, 'hFFF, 'h000};
        for (int i = 0; i < 3; i++) begin
            dac_modu = 12'(xs[i]);
            step();
            step();
            n_vec++;
            if (dac_modu_ampl !== 12'(xs[i])) begin
                n_err++; $display("FAIL passthrough in %h got %h exp %h", xs[i], dac_modu_ampl, xs[i]);
            end
        end
    endtask

    task automatic test_saturation();
        int xs[3] = '{'hFFF, 'h000, 'h810};
        int es[3] = '{'hFFF, 'h000, 'h81F};
        do_reset();
        apply_cfg(255, 0, 0);
        for (int n = 0; n <= 127; n++) begin
            n_vec++;
            if (ramp_done !== 1'(n == 127)) begin n_err++; $display("FAIL sat_done n=%0d got %b", n, ramp_done); end
            if (n < 127) step();
        end
        n_vec++; if (gain_cur !== 8'd255) begin n_err++; $display("FAIL sat_gain got %0d exp 255", gain_cur); end
        step();
        m_gain = 255;
        for (int i = 0; i < 3; i++) begin
            dac_modu = 12'(xs[i]);
            step();
            step();
            n_vec++;
            if (dac_modu_ampl !== 12'(es[i])) begin
                n_err++; $display("FAIL sat_out in %h got %h exp %h", xs[i], dac_modu_ampl, es[i]);
            end
        end
    endtask

    task automatic test_ramp_timing();
        int eg;
        int eo;
        do_reset();
        dac_modu = 12'h800;
        step();
        apply_cfg(130, 10, 3);
        for (int n = 0; n <= 13; n++) begin
            eg = toward(128, 130, 1, n / 4);
            n_vec++; if (gain_cur !== 8'(eg)) begin n_err++; $display("FAIL rt_gain n=%0d got %0d exp %0d", n, gain_cur, eg); end
            n_vec++; if (busy !== 1'(n < 12)) begin n_err++; $display("FAIL rt_busy n=%0d got %b exp %b", n, busy, n < 12); end
            n_vec++; if (ramp_done !== 1'(n == 12)) begin n_err++; $display("FAIL rt_done n=%0d got %b", n, ramp_done); end
            n_vec++; if (cfg_ready !== 1'(n > 12)) begin n_err++; $display("FAIL rt_ready n=%0d got %b", n, cfg_ready); end
            if (n >= 2) begin
                eo = 2048 + toward(0, 10, 4, (n - 2) / 4);
                n_vec++; if (dac_modu_ampl !== 12'(eo)) begin n_err++; $display("FAIL rt_ofs n=%0d got %0d exp %0d", n, dac_modu_ampl, eo); end
            end
            if (n < 13) step();
        end
        m_gain = 130;
        m_ofs  = 10;
    endtask

    task automatic test_down_ramp();
        do_reset();
        dac_modu = 12'h800;
        step();
        apply_cfg(64, -6, 0);
        for (int n = 0; n <= 65; n++) begin
            if (n == 1) begin n_vec++; if (gain_cur !== 8'd127) begin n_err++; $display("FAIL down_gain1 got %0d exp 127", gain_cur); end end
            if (n == 3) begin n_vec++; if (dac_modu_ampl !== 12'd2044) begin n_err++; $display("FAIL down_ofs1 got %0d exp 2044", dac_modu_ampl); end end
            if (n == 4) begin n_vec++; if (dac_modu_ampl !== 12'd2042) begin n_err++; $display("FAIL down_ofs2 got %0d exp 2042", dac_modu_ampl); end end
            n_vec++;
            if (ramp_done !== 1'(n == 64)) begin n_err++; $display("FAIL down_done n=%0d got %b", n, ramp_done); end
            if (n < 65) step();
        end
        n_vec++; if (gain_cur !== 8'd64) begin n_err++; $display("FAIL down_gain got %0d exp 64", gain_cur); end
        m_gain = 64;
        m_ofs  = -6;
        dac_modu = 12'h900;
        step();
        step();
        n_vec++; if (dac_modu_ampl !== 12'h87A) begin n_err++; $display("FAIL down_out got %h exp 87A", dac_modu_ampl); end
    endtask

    task automatic test_noop();
        apply_cfg(m_gain, m_ofs, 5);
        n_vec++; if (ramp_done !== 1'b1) begin n_err++; $display("FAIL noop_done got %b exp 1", ramp_done); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL noop_busy got %b exp 0", busy); end
        n_vec++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL noop_ready0 got %b exp 0", cfg_ready); end
        step();
        n_vec++; if (ramp_done !== 1'b0) begin n_err++; $display("FAIL noop_pulse got %b exp 0", ramp_done); end
        n_vec++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL noop_ready1 got %b exp 1", cfg_ready); end
        n_vec++; if (gain_cur !== 8'(m_gain)) begin n_err++; $display("FAIL noop_gain got %0d exp %0d", gain_cur, m_gain); end
    endtask

    task automatic test_busy_reject();
        int t;
        int eg;
        t = n_ticks(m_gain, 70, m_ofs, -2) * 2;
        dac_modu = 12'h800;
        apply_cfg(70, -2, 1);
        for (int n = 0; n <= t + 1; n++) begin
            if (n == 3) begin cfg_gain = 8'd0; cfg_offset = 12'd0; cfg_valid = 1'b1; end
            if (n == 5) cfg_valid = 1'b0;
            eg = toward(m_gain, 70, 1, n / 2);
            n_vec++; if (gain_cur !== 8'(eg)) begin n_err++; $display("FAIL rej_gain n=%0d got %0d exp %0d", n, gain_cur, eg); end
            n_vec++; if (ramp_done !== 1'(n == t)) begin n_err++; $display("FAIL rej_done n=%0d got %b", n, ramp_done); end
            if (n < t + 1) step();
        end
        n_vec++; if (dac_modu_ampl !== 12'd2046) begin n_err++; $display("FAIL rej_ofs got %0d exp 2046", dac_modu_ampl); end
        m_gain = 70;
        m_ofs  = -2;
    endtask

    task automatic test_reset_mid_ramp();
        do_reset();
        dac_modu = 12'h900;
        apply_cfg(140, 20, 2);
        repeat (6) step();
        rst = 1'b0;
        #1;
        n_vec++; if (dac_modu_ampl !== 12'h800) begin n_err++; $display("FAIL mid_out got %h exp 800", dac_modu_ampl); end
        n_vec++; if (gain_cur !== 8'd128) begin n_err++; $display("FAIL mid_gain got %0d exp 128", gain_cur); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy got %b exp 0", busy); end
        n_vec++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL mid_ready got %b exp 1", cfg_ready); end
        #3;
        rst = 1'b1;
        step();
        m_gain = 128;
        m_ofs  = 0;
        apply_cfg(129, 0, 0);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_rebusy got %b exp 1", busy); end
        step();
        n_vec++; if (ramp_done !== 1'b1) begin n_err++; $display("FAIL mid_redone got %b exp 1", ramp_done); end
        n_vec++; if (gain_cur !== 8'd129) begin n_err++; $display("FAIL mid_regain got %0d exp 129", gain_cur); end
        step();
        m_gain = 129;
    endtask

    task automatic test_random();
        int gt, ot, d, t, eg, eo, x, e;
        int q[$];
        for (int it = 0; it < 15; it++) begin
            gt = ($urandom_range(0, 4) == 0) ? m_gain : int'($urandom_range(0, 255));
            ot = ($urandom_range(0, 4) == 0) ? m_ofs : int'($urandom_range(0, 400)) - 200;
            d  = int'($urandom_range(0, 3));
            t  = n_ticks(m_gain, gt, m_ofs, ot) * (d + 1);
            dac_modu = 12'h800;
            apply_cfg(gt, ot, d);
            for (int n = 0; n <= t + 1; n++) begin
                if (n == 1 && t > 3) begin cfg_gain = 8'($urandom_range(0, 255)); cfg_valid = 1'b1; end
                if (n == 3) cfg_valid = 1'b0;
                eg = toward(m_gain, gt, 1, n / (d + 1));
                n_vec++; if (gain_cur !== 8'(eg)) begin n_err++; $display("FAIL rnd_gain it=%0d n=%0d got %0d exp %0d", it, n, gain_cur, eg); end
                n_vec++; if (ramp_done !== 1'(n == t)) begin n_err++; $display("FAIL rnd_done it=%0d n=%0d got %b", it, n, ramp_done); end
                n_vec++; if (cfg_ready !== 1'(n > t)) begin n_err++; $display("FAIL rnd_ready it=%0d n=%0d got %b", it, n, cfg_ready); end
                if (n >= 2) begin
                    eo = exp_out(2048, 128, toward(m_ofs, ot, 4, (n - 2) / (d + 1)));
                    n_vec++; if (dac_modu_ampl !== 12'(eo)) begin n_err++; $display("FAIL rnd_ofs it=%0d n=%0d got %0d exp %0d", it, n, dac_modu_ampl, eo); end
                end
                if (n < t + 1) step();
            end
            cfg_valid = 1'b0;
            m_gain = gt;
            m_ofs  = ot;
            q.delete();
            for (int j = 0; j < 10; j++) begin
                if (j >= 2) begin
                    e = q.pop_front();
                    n_vec++; if (dac_modu_ampl !== 12'(e)) begin n_err++; $display("FAIL rnd_out it=%0d j=%0d got %h exp %h", it, j, dac_modu_ampl, e); end
                end
                if (j < 8) begin
                    x = int'($urandom_range(0, 4095));
                    dac_modu = 12'(x);
                    q.push_back(exp_out(x, m_gain, m_ofs));
                end
                step();
            end
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_saturation();
        test_ramp_timing();
        test_down_ramp();
        test_noop();
        test_busy_reject();
        test_reset_mid_ramp();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
